// File: rtl/shift_reg_bank.sv
// Shift/load/rotate register bank with saturating fill count.
// Optional sync clear port enabled by SHIFT_REG_BANK_SYNC_CLR_EN.
module shift_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst_n,
`ifdef SHIFT_REG_BANK_SYNC_CLR_EN
  input  logic                       clr,
`endif
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           din,
  input  logic [DEPTH*WIDTH-1:0]     pdin,
  output logic [WIDTH-1:0]           q,
  output logic [DEPTH*WIDTH-1:0]     pq,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] stg_q, stg_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic                        full_q, full_d;

  always_comb begin
    stg_d  = stg_q;
    fill_d = fill_q;
    if (en) begin
      unique case (mode)
        2'b01: begin
          stg_d[0] = din;
          for (int i = 1; i < DEPTH; i++)
            stg_d[i] = stg_q[i-1];
          if (fill_q != FULL_CNT)
            fill_d = fill_q + FW'(1);
        end
        2'b10: begin
          stg_d  = pdin;
          fill_d = FULL_CNT;
        end
        2'b11: begin
          stg_d[0] = stg_q[DEPTH-1];
          for (int i = 1; i < DEPTH; i++)
            stg_d[i] = stg_q[i-1];
        end
        default: ;
      endcase
    end
`ifdef SHIFT_REG_BANK_SYNC_CLR_EN
    if (clr) begin
      stg_d  = {DEPTH{RST_VAL}};
      fill_d = '0;
    end
`endif
    // full derives from next fill so both move on the same edge
    full_d = (fill_d == FULL_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q  <= {DEPTH{RST_VAL}};
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      stg_q  <= stg_d;
      fill_q <= fill_d;
      full_q <= full_d;
    end
  end

  assign q    = stg_q[DEPTH-1];
  assign pq   = stg_q;
  assign fill = fill_q;
  assign full = full_q;

endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed self-checking bench for shift_reg_bank (WIDTH=8, DEPTH=4).
// Define SHIFT_REG_BANK_SYNC_CLR_EN to also exercise the clr port.
module tb_shift_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  din;
  logic [31:0] pdin;
  logic [7:0]  q;
  logic [31:0] pq;
  logic [2:0]  fill;
  logic        full;
`ifdef SHIFT_REG_BANK_SYNC_CLR_EN
  logic        clr;
`endif

  int checks;
  int errors;

  shift_reg_bank #(
    .WIDTH(8),
    .DEPTH(4),
    .RST_VAL(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
`ifdef SHIFT_REG_BANK_SYNC_CLR_EN
    .clr  (clr),
`endif
    .en   (en),
    .mode (mode),
    .din  (din),
    .pdin (pdin),
    .q    (q),
    .pq   (pq),
    .fill (fill),
    .full (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic op(input logic e, input logic [1:0] m,
                    input logic [7:0] d, input logic [31:0] p);
    en   = e;
    mode = m;
    din  = d;
    pdin = p;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    checks++;
    if (pq !== 32'h0) begin
      errors++;
      $display("FAIL reset_pq: got %h exp %h", pq, 32'h0);
    end
    checks++;
    if (fill !== 3'd0 || full !== 1'b0 || q !== 8'h00) begin
      errors++;
      $display("FAIL reset_cnt: got fill=%0d full=%b q=%h exp 0 0 00",
               fill, full, q);
    end
  endtask

  task automatic test_async_reset();
    op(1'b1, 2'b10, 8'h00, 32'hDEADBEEF);
    checks++;
    if (pq !== 32'hDEADBEEF || fill !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL load_deadbeef: got pq=%h fill=%0d full=%b exp deadbeef 4 1",
               pq, fill, full);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pq !== 32'h0 || fill !== 3'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got pq=%h fill=%0d full=%b exp 0 0 0",
               pq, fill, full);
    end
    pdin = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    checks++;
    if (pq !== 32'h0 || fill !== 3'd0) begin
      errors++;
      $display("FAIL reset_ignores_inputs: got pq=%h fill=%0d exp 0 0",
               pq, fill);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pq !== 32'hFFFFFFFF || fill !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL first_op_after_release: got pq=%h fill=%0d full=%b exp ffffffff 4 1",
               pq, fill, full);
    end
  endtask

  task automatic test_shift();
    logic [7:0] dv [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    logic [2:0] fv [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic       uv [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    pulse_reset();
    for (int i = 0; i < 5; i++) begin
      op(1'b1, 2'b01, dv[i], 32'h0);
      checks++;
      if (fill !== fv[i] || full !== uv[i]) begin
        errors++;
        $display("FAIL shift_fill[%0d]: got fill=%0d full=%b exp %0d %b",
                 i, fill, full, fv[i], uv[i]);
      end
    end
    checks++;
    if (pq !== 32'h22334455 || q !== 8'h22) begin
      errors++;
      $display("FAIL shift_data: got pq=%h q=%h exp 22334455 22", pq, q);
    end
  endtask

  task automatic test_rotate();
    logic [31:0] ev [4] = '{32'hB2C3D4A1, 32'hC3D4A1B2,
                            32'hD4A1B2C3, 32'hA1B2C3D4};
    pulse_reset();
    op(1'b1, 2'b10, 8'h00, 32'hA1B2C3D4);
    for (int i = 0; i < 4; i++) begin
      op(1'b1, 2'b11, 8'h99, 32'h0);
      checks++;
      if (pq !== ev[i] || fill !== 3'd4 || full !== 1'b1) begin
        errors++;
        $display("FAIL rotate[%0d]: got pq=%h fill=%0d full=%b exp %h 4 1",
                 i, pq, fill, full, ev[i]);
      end
    end
  endtask

  task automatic test_hold();
    op(1'b1, 2'b10, 8'h00, 32'h01020304);
    for (int i = 0; i < 3; i++) begin
      op(1'b0, 2'b01, 8'hEE, 32'hFFFFFFFF);
      checks++;
      if (pq !== 32'h01020304 || fill !== 3'd4 || full !== 1'b1) begin
        errors++;
        $display("FAIL hold_en0[%0d]: got pq=%h fill=%0d exp 01020304 4",
                 i, pq, fill);
      end
    end
    pulse_reset();
    op(1'b1, 2'b01, 8'h5A, 32'h0);
    op(1'b1, 2'b00, 8'hA5, 32'hFFFFFFFF);
    checks++;
    if (pq !== 32'h0000005A || fill !== 3'd1 || full !== 1'b0) begin
      errors++;
      $display("FAIL hold_mode00: got pq=%h fill=%0d full=%b exp 0000005a 1 0",
               pq, fill, full);
    end
    op(1'b1, 2'b11, 8'h00, 32'h0);
    checks++;
    if (pq !== 32'h00005A00 || fill !== 3'd1) begin
      errors++;
      $display("FAIL rotate_partial: got pq=%h fill=%0d exp 00005a00 1",
               pq, fill);
    end
  endtask

  task automatic test_back_to_back();
    op(1'b1, 2'b10, 8'h00, 32'h00000000);
    checks++;
    if (pq !== 32'h00000000 || fill !== 3'd4) begin
      errors++;
      $display("FAIL b2b_load: got pq=%h fill=%0d exp 00000000 4", pq, fill);
    end
    op(1'b1, 2'b01, 8'hFF, 32'h0);
    checks++;
    if (pq !== 32'h000000FF || fill !== 3'd4) begin
      errors++;
      $display("FAIL b2b_shift: got pq=%h fill=%0d exp 000000ff 4", pq, fill);
    end
    op(1'b1, 2'b11, 8'h00, 32'h0);
    checks++;
    if (pq !== 32'h0000FF00 || fill !== 3'd4 || full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_rotate: got pq=%h fill=%0d exp 0000ff00 4", pq, fill);
    end
  endtask

`ifdef SHIFT_REG_BANK_SYNC_CLR_EN
  task automatic test_clr();
    clr = 1'b1;
    op(1'b1, 2'b10, 8'h00, 32'hFFFFFFFF);
    clr = 1'b0;
    checks++;
    if (pq !== 32'h0 || fill !== 3'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL clr_priority: got pq=%h fill=%0d full=%b exp 0 0 0",
               pq, fill, full);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    mode   = 2'b00;
    din    = 8'h00;
    pdin   = 32'h0;
`ifdef SHIFT_REG_BANK_SYNC_CLR_EN
    clr    = 1'b0;
`endif
    #12;
    test_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_async_reset();
    test_shift();
    test_rotate();
    test_hold();
    test_back_to_back();
`ifdef SHIFT_REG_BANK_SYNC_CLR_EN
    test_clr();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
